// File: rtl/cim_gemv_sequencer.sv
// cim_gemv_sequencer
// Sequences one matrix-vector product (M rows x K words) on the CIM core.
// For every word it reads the input word and then the weight word over SRAM
// port B, pairs them and presents them to the MAC array (one MAC word every
// two cycles). After the last word of a row it waits for the MAC result,
// offers it on a valid/ready port, then moves on to the next row.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start, abort             job control (start latches cfg_*)
//   cfg_m, cfg_k             rows, words per row
//   cfg_in_base              input vector base word address
//   cfg_w_base               weight base (row-major, rows contiguous)
//   cfg_out_base             result base address
//   busy, done, err          job status (done/err are 1-cycle pulses)
//   sram_en, sram_addr       port-B read request
//   sram_rdata               port-B data, one cycle after sram_en
//   mac_vld/first/last       MAC word strobe and row framing
//   mac_in, mac_w            input / weight word to the MAC
//   mac_res_vld, mac_res     row result from the MAC
//   res_valid/ready/data/addr  result hand-off to the consumer
//   perf_cycles              busy-cycle count, saturating
module cim_gemv_sequencer #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              mac_vld,
  output logic              mac_first,
  output logic              mac_last,
  output logic [DATA_W-1:0] mac_in,
  output logic [DATA_W-1:0] mac_w,
  input  logic              mac_res_vld,
  input  logic [ACC_W-1:0]  mac_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_addr,
  output logic [31:0]       perf_cycles
);

  typedef enum logic [2:0] {IDLE, RD_IN, RD_W, WAIT_RES, OUT} state_t;

  state_t state, state_nxt;

  logic [DIM_W-1:0]  m_lat, k_lat, m_cnt, k_cnt;
  logic [ADDR_W-1:0] in_base, out_base, w_ptr;
  logic [DATA_W-1:0] in_p0;
  logic              vld_p0, first_p0, last_p0;

  logic start_ok, start_bad, abort_act, k_end, m_end, res_hs, beat_en;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign start_ok  = (state == IDLE) && start && (cfg_m != '0) && (cfg_k != '0);
  assign start_bad = (state == IDLE) && start && ((cfg_m == '0) || (cfg_k == '0));
  assign abort_act = abort && (state != IDLE);
  assign k_end     = (k_cnt == k_lat - DIM_W'(1));
  assign m_end     = (m_cnt == m_lat - DIM_W'(1));
  assign res_hs    = res_valid && res_ready;
  assign beat_en   = vld_p0 && !abort_act;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sram_en   = 1'b0;
    sram_addr = '0;
    case (state)
      IDLE:     if (start_ok) state_nxt = RD_IN;
      RD_IN: begin
        sram_en   = 1'b1;
        sram_addr = in_base + ADDR_W'(k_cnt);
        state_nxt = RD_W;
      end
      RD_W: begin
        sram_en   = 1'b1;
        sram_addr = w_ptr;
        state_nxt = k_end ? WAIT_RES : RD_IN;
      end
      WAIT_RES: if (mac_res_vld) state_nxt = OUT;
      OUT:      if (res_hs) state_nxt = m_end ? IDLE : RD_IN;
      default:  state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  // Stage p0: input word captured at the end of RD_W; the weight word is
  // on sram_rdata during the following cycle.
  always_ff @(posedge clk) begin
    if (state == RD_W) in_p0 <= sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_lat       <= '0;
      k_lat       <= '0;
      m_cnt       <= '0;
      k_cnt       <= '0;
      in_base     <= '0;
      out_base    <= '0;
      w_ptr       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      perf_cycles <= '0;
      vld_p0      <= 1'b0;
      first_p0    <= 1'b0;
      last_p0     <= 1'b0;
      mac_vld     <= 1'b0;
      mac_first   <= 1'b0;
      mac_last    <= 1'b0;
      mac_in      <= '0;
      mac_w       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_addr    <= '0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      vld_p0 <= 1'b0;
      // Stage p1: pair input and weight into the MAC word.
      mac_vld   <= beat_en;
      mac_first <= beat_en && first_p0;
      mac_last  <= beat_en && last_p0;
      if (vld_p0) begin
        mac_in <= in_p0;
        mac_w  <= sram_rdata;
      end
      if (busy) perf_cycles <= sat_inc(perf_cycles);

      if (abort_act) begin
        busy      <= 1'b0;
        res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              m_lat       <= cfg_m;
              k_lat       <= cfg_k;
              in_base     <= cfg_in_base;
              out_base    <= cfg_out_base;
              w_ptr       <= cfg_w_base;
              m_cnt       <= '0;
              k_cnt       <= '0;
              perf_cycles <= '0;
              busy        <= 1'b1;
            end else if (start_bad) begin
              err <= 1'b1;
            end
          end
          RD_W: begin
            vld_p0   <= 1'b1;
            first_p0 <= (k_cnt == '0);
            last_p0  <= k_end;
            // Rows are contiguous, so the weight pointer simply keeps
            // counting across row boundaries.
            w_ptr    <= w_ptr + ADDR_W'(1);
            if (!k_end) k_cnt <= k_cnt + DIM_W'(1);
          end
          WAIT_RES: begin
            if (mac_res_vld) begin
              res_valid <= 1'b1;
              res_data  <= mac_res;
              res_addr  <= out_base + ADDR_W'(m_cnt);
            end
          end
          OUT: begin
            if (res_hs) begin
              res_valid <= 1'b0;
              if (m_end) begin
                busy <= 1'b0;
                done <= 1'b1;
              end else begin
                m_cnt <= m_cnt + DIM_W'(1);
                k_cnt <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
